palindrome_generator: RTL and testbench

PALINDROME_GENERATOR -- requirements
Module: palindrome_generator

---
 rtl/symgen_pkg.sv | 35 +++
 rtl/symgen_next.sv | 30 +++
 rtl/palindrome_generator.sv | 138 +++++++++++++
 tb/tb_palindrome_generator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/symgen_pkg.sv
// rtl/symgen_pkg.sv - shared types and constants for the palindrome generator
//
// Contents:
//   state_e     : sequencing FSM states (IDLE, LOAD, SEND, DONE)
//   mode_e      : next-half-word rules (increment, decrement, LFSR, hold)
//   LFSR_TAPS   : feedback tap mask for the 4-bit LFSR (bits 3 and 2)
//   LFSR_SEED_Z : value substituted for an all-zero LFSR seed (lock-up state)
//   mirror_word : builds the 8-bit palindrome from a 4-bit half-word
package symgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_SEND = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        MODE_INC  = 2'b00,
        MODE_DEC  = 2'b01,
        MODE_LFSR = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Feedback bit is the XOR of h[3] and h[2].
    localparam logic [3:0] LFSR_TAPS   = 4'b1100;
    // All-zero is the LFSR lock-up state, so a zero seed is replaced by this.
    localparam logic [3:0] LFSR_SEED_Z = 4'h1;

    // Upper nibble is the bit-reversed lower nibble, so bit k equals bit 7-k.
    function automatic logic [7:0] mirror_word(input logic [3:0] h);
        return {h[0], h[1], h[2], h[3], h};
    endfunction

endpackage

// File: rtl/symgen_next.sv
// rtl/symgen_next.sv - combinational next-half-word computation
//
// Ports:
//   h_i      : current half-word
//   mode_i   : rule selector (inc / dec / LFSR / hold)
//   h_next_o : half-word to use after the next accepted word
module symgen_next
    import symgen_pkg::*;
(
    input  logic [3:0] h_i,
    input  mode_e      mode_i,
    output logic [3:0] h_next_o
);

    logic feedback;

    assign feedback = ^(h_i & LFSR_TAPS);

    always_comb begin
        h_next_o = h_i;
        case (mode_i)
            MODE_INC:  h_next_o = h_i + 4'd1;   // wraps F -> 0
            MODE_DEC:  h_next_o = h_i - 4'd1;   // wraps 0 -> F
            MODE_LFSR: h_next_o = {h_i[2:0], feedback};
            MODE_HOLD: h_next_o = h_i;
            default:   h_next_o = h_i;
        endcase
    end

endmodule

// File: rtl/palindrome_generator.sv
// rtl/palindrome_generator.sv - streams SEQ_LEN palindromic bytes per start
//
// Optional feature macro: SYMGEN_ERR_INJECT_EN (single-bit error injection).
//
// Parameters:
//   SEQ_LEN   : words per sequence (1..16)
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : begin a sequence (honoured in IDLE only)
//   stop      : abort the current sequence, wins over start and handshake
//   seed      : initial half-word, captured with start
//   mode      : next-half-word rule, captured with start
//   out_ready : consumer ready
//   out_valid : out_data valid (high throughout SEND)
//   out_data  : palindromic byte
//   busy      : high in LOAD and SEND
//   done      : one-cycle pulse after the last accepted word
//   word_idx  : words accepted in the current sequence
//   inj_en    : flip out_data[inj_pos] when injection is built in
//   inj_pos   : bit position to flip
module palindrome_generator
    import symgen_pkg::*;
#(
    parameter int SEQ_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] seed,
    input  logic [1:0] mode,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       done,
    output logic [3:0] word_idx,
    input  logic       inj_en,
    input  logic [2:0] inj_pos
);

    localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);

    state_e     state_q, state_d;
    logic [3:0] h_q, h_d;
    mode_e      mode_q, mode_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] h_next;
    logic [7:0] pal_word;

    symgen_next u_next (
        .h_i      (h_q),
        .mode_i   (mode_q),
        .h_next_o (h_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            h_q     <= 4'h0;
            mode_q  <= MODE_INC;
            idx_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                // seed/mode are captured only here, so later changes are ignored
                if (start && !stop) begin
                    state_d = ST_LOAD;
                    h_d     = seed;
                    mode_d  = mode_e'(mode);
                    idx_d   = 4'h0;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    idx_d   = 4'h0;
                end else begin
                    state_d = ST_SEND;
                    if (mode_q == MODE_LFSR && h_q == 4'h0) begin
                        h_d = LFSR_SEED_Z;
                    end
                end
            end
            ST_SEND: begin
                // stop outranks a handshake in the same cycle
                if (stop) begin
                    state_d = ST_IDLE;
                    idx_d   = 4'h0;
                end else if (out_ready) begin
                    h_d   = h_next;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pal_word  = mirror_word(h_q);
    assign out_valid = (state_q == ST_SEND);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_SEND);
    assign done      = (state_q == ST_DONE);
    assign word_idx  = idx_q;

`ifdef SYMGEN_ERR_INJECT_EN
    logic [7:0] inj_mask;

    assign inj_mask = inj_en ? (8'h01 << inj_pos) : 8'h00;
    assign out_data = out_valid ? (pal_word ^ inj_mask) : 8'h00;
`else
    logic unused_inj;

    assign unused_inj = ^{inj_en, inj_pos};
    assign out_data   = out_valid ? pal_word : 8'h00;
`endif

endmodule

// File: tb/tb_palindrome_generator.sv
// tb/tb_palindrome_generator.sv - directed, table-driven bench for palindrome_generator
module tb_palindrome_generator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] seed;
    logic [1:0] mode;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic [3:0] word_idx;
    logic       inj_en;
    logic [2:0] inj_pos;

    int n_pass;
    int n_total;

    typedef struct {
        logic [3:0]      seed;
        logic [1:0]      mode;
        logic [3:0][7:0] exp;   // exp[0] is the first word
    } vec_t;

    vec_t vecs [6];

    palindrome_generator #(.SEQ_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .seed      (seed),
        .mode      (mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .word_idx  (word_idx),
        .inj_en    (inj_en),
        .inj_pos   (inj_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with the block in IDLE; returns at a negedge in IDLE.
    task automatic run_seq(input string tag, input logic [3:0] sd, input logic [1:0] md,
                           input logic [3:0][7:0] exp);
        start = 1'b1; seed = sd; mode = md; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; seed = ~sd; mode = md + 2'd1;   // must be ignored
        check({tag, " load busy"}, {7'd0, busy}, 8'h01);
        check({tag, " load valid"}, {7'd0, out_valid}, 8'h00);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            check($sformatf("%s w%0d valid", tag, w), {7'd0, out_valid}, 8'h01);
            check($sformatf("%s w%0d data", tag, w), out_data, exp[w]);
            check($sformatf("%s w%0d idx", tag, w), {4'd0, word_idx}, 8'(w));
        end
        @(negedge clk);
        check({tag, " done pulse"}, {7'd0, done}, 8'h01);
        check({tag, " done valid"}, {7'd0, out_valid}, 8'h00);
        @(negedge clk);
        check({tag, " done end"}, {7'd0, done}, 8'h00);
        check({tag, " idle busy"}, {7'd0, busy}, 8'h00);
    endtask

    // Starts seed=1/inc and returns at the negedge where word_idx has reached 2.
    task automatic two_words();
        start = 1'b1; seed = 4'h1; mode = 2'b00; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("two words idx", {4'd0, word_idx}, 8'h02);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; seed = 4'h0; mode = 2'b00;
        out_ready = 1'b0; inj_en = 1'b0; inj_pos = 3'd0;

        vecs[0] = '{seed: 4'h1, mode: 2'b00, exp: {8'h24, 8'hC3, 8'h42, 8'h81}};
        vecs[1] = '{seed: 4'h0, mode: 2'b01, exp: {8'hBD, 8'h7E, 8'hFF, 8'h00}};
        vecs[2] = '{seed: 4'h0, mode: 2'b10, exp: {8'h99, 8'h24, 8'h42, 8'h81}};
        vecs[3] = '{seed: 4'h5, mode: 2'b11, exp: {8'hA5, 8'hA5, 8'hA5, 8'hA5}};
        vecs[4] = '{seed: 4'hE, mode: 2'b00, exp: {8'h81, 8'h00, 8'hFF, 8'h7E}};
        vecs[5] = '{seed: 4'h8, mode: 2'b10, exp: {8'h24, 8'h42, 8'h81, 8'h18}};

        #2;
        check("reset valid", {7'd0, out_valid}, 8'h00);
        check("reset data", out_data, 8'h00);
        check("reset busy", {7'd0, busy}, 8'h00);
        check("reset done", {7'd0, done}, 8'h00);
        check("reset idx", {4'd0, word_idx}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_seq($sformatf("vec%0d", i), vecs[i].seed, vecs[i].mode, vecs[i].exp);
        end

        // Backpressure on the first word, with a stray start that must be ignored.
        start = 1'b1; seed = 4'h1; mode = 2'b00; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d valid", c), {7'd0, out_valid}, 8'h01);
            check($sformatf("stall%0d data", c), out_data, 8'h81);
            check($sformatf("stall%0d idx", c), {4'd0, word_idx}, 8'h00);
            start = (c == 0); seed = 4'h9;
        end
        start = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("stall resume data", out_data, 8'h42);
        check("stall resume idx", {4'd0, word_idx}, 8'h01);
        @(negedge clk);
        check("stall w2 data", out_data, 8'hC3);
        @(negedge clk);
        check("stall w3 data", out_data, 8'h24);
        @(negedge clk);
        check("stall done", {7'd0, done}, 8'h01);
        @(negedge clk);

        // Stop after the second word, out_ready still high.
        two_words();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop valid", {7'd0, out_valid}, 8'h00);
        check("stop busy", {7'd0, busy}, 8'h00);
        check("stop done", {7'd0, done}, 8'h00);
        @(negedge clk);
        check("stop no done", {7'd0, done}, 8'h00);
        run_seq("after stop", 4'h1, 2'b00, vecs[0].exp);

        // Reset after the second word.
        two_words();
        rst_n = 1'b0;
        #1;
        check("rst valid", {7'd0, out_valid}, 8'h00);
        check("rst busy", {7'd0, busy}, 8'h00);
        check("rst idx", {4'd0, word_idx}, 8'h00);
        check("rst data", out_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post rst%0d done", c), {7'd0, done}, 8'h00);
            check($sformatf("post rst%0d busy", c), {7'd0, busy}, 8'h00);
        end
        run_seq("after rst", 4'h1, 2'b00, vecs[0].exp);

        // start and stop together in IDLE: stay idle.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("start+stop busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        check("start+stop busy2", {7'd0, busy}, 8'h00);
        check("start+stop valid", {7'd0, out_valid}, 8'h00);

        // Error injection on bit 0.
        start = 1'b1; seed = 4'h1; mode = 2'b00; out_ready = 1'b0;
        inj_en = 1'b1; inj_pos = 3'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
`ifdef SYMGEN_ERR_INJECT_EN
        check("inject data", out_data, 8'h80);
`else
        check("inject data", out_data, 8'h81);
`endif
        inj_en = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("inject abort valid", {7'd0, out_valid}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
